// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: branch/jump types and data-memory FSM states.
package mem_access_stage_pkg;

  localparam logic [1:0] JT_NONE = 2'd0;
  localparam logic [1:0] JT_BEQ  = 2'd1;
  localparam logic [1:0] JT_BNE  = 2'd2;
  localparam logic [1:0] JT_J    = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble kills the write-enable and holds the rest.
module mem_wb_reg (
  input  logic        clk,
  input  logic        clr,
  input  logic        bubble,
  input  logic        wreg,
  input  logic        m2reg,
  input  logic [4:0]  wn,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  output logic        WBwreg,
  output logic        WBm2reg,
  output logic [4:0]  WBwn,
  output logic [31:0] WBaluResult,
  output logic [31:0] WBmemData
);

  always_ff @(posedge clk) begin
    if (clr) begin
      WBwreg      <= 1'b0;
      WBm2reg     <= 1'b0;
      WBwn        <= '0;
      WBaluResult <= '0;
      WBmemData   <= '0;
    end else if (bubble) begin
      WBwreg      <= 1'b0;
    end else begin
      WBwreg      <= wreg;
      WBm2reg     <= m2reg;
      WBwn        <= wn;
      WBaluResult <= alu_result;
      WBmemData   <= mem_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack access with wait-state timeout, branch resolution,
// and the MEM/WB register.
//   state   | meaning
//   IDLE    | no access outstanding; an aligned op issues dm_req this cycle
//   WAIT    | access outstanding, pipeline stalled until dm_ack or timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int          DM_TIMEOUT = 16,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MEMwreg,
  input  logic        MEMm2reg,
  input  logic        MEMwmem,
  input  logic [4:0]  MEMwn,
  input  logic [31:0] MEMaluResult,
  input  logic [31:0] MEMdi,
  input  logic [1:0]  MEMjumpType,
  input  logic [31:0] MEMjumpPc,
  input  logic        MEMzero,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        WBwreg,
  output logic        WBm2reg,
  output logic [4:0]  WBwn,
  output logic [31:0] WBaluResult,
  output logic [31:0] WBmemData,
  output logic        dm_err
);

  localparam int CW = $clog2(DM_TIMEOUT + 1);

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          mem_op, misaligned, aligned_op, timeout, err_now, taken;
  logic [31:0]   wb_mem_data;

  always_comb begin
    mem_op      = MEMm2reg | MEMwmem;
    misaligned  = |MEMaluResult[1:0];
    aligned_op  = mem_op & ~misaligned;
    dm_req      = (state == ST_WAIT) ? 1'b1 : aligned_op;
    dm_we       = MEMwmem;
    dm_addr     = MEMaluResult;
    dm_wdata    = MEMdi;
    // Ack on the final counted cycle still wins over the timeout.
    timeout     = (state == ST_WAIT) & ~dm_ack & (wait_cnt == CW'(DM_TIMEOUT));
    stall       = dm_req & ~dm_ack & ~timeout;
    err_now     = ((state == ST_IDLE) & mem_op & misaligned) | timeout;
    wb_mem_data = err_now ? ERR_RDATA : dm_rdata;
    taken       = 1'b0;
    case (MEMjumpType)
      JT_BEQ:  taken = MEMzero;
      JT_BNE:  taken = ~MEMzero;
      JT_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    redirect    = taken & ~stall;
    redirect_pc = MEMjumpPc;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dm_err   <= 1'b0;
    end else begin
      dm_err <= dm_err | err_now;
      case (state)
        ST_IDLE: begin
          if (aligned_op & ~dm_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        default: begin
          if (dm_ack | timeout) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .clr         (clr),
    .bubble      (stall),
    .wreg        (MEMwreg),
    .m2reg       (MEMm2reg),
    .wn          (MEMwn),
    .alu_result  (MEMaluResult),
    .mem_data    (wb_mem_data),
    .WBwreg      (WBwreg),
    .WBm2reg     (WBm2reg),
    .WBwn        (WBwn),
    .WBaluResult (WBaluResult),
    .WBmemData   (WBmemData)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboarded MEM/WB results, bench-side memory model.
module tb_mem_access_stage;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        clr;
  logic        MEMwreg, MEMm2reg, MEMwmem, MEMzero;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMdi, MEMjumpPc;
  logic [1:0]  MEMjumpType;
  logic        dm_req, dm_we, dm_ack, stall, redirect, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, redirect_pc;
  logic        WBwreg, WBm2reg;
  logic [4:0]  WBwn;
  logic [31:0] WBaluResult, WBmemData;

  typedef struct {
    logic        wreg;
    logic        m2reg;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic [31:0] mdata;
  } wb_t;

  wb_t         sb[$];
  logic [31:0] mem_model [logic [31:0]];
  logic        err_exp = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DM_TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .clr(clr),
    .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem), .MEMwn(MEMwn),
    .MEMaluResult(MEMaluResult), .MEMdi(MEMdi), .MEMjumpType(MEMjumpType),
    .MEMjumpPc(MEMjumpPc), .MEMzero(MEMzero),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
    .WBaluResult(WBaluResult), .WBmemData(WBmemData), .dm_err(dm_err)
  );

  task automatic drive_nop();
    MEMwreg = 1'b0; MEMm2reg = 1'b0; MEMwmem = 1'b0; MEMwn = '0;
    MEMaluResult = '0; MEMdi = '0; MEMjumpType = 2'd0; MEMjumpPc = '0; MEMzero = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0;
  endtask

  // Entered and left at a negedge; ack_delay < 0 means the memory never acks.
  task automatic do_op(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] wn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] jt, input logic zero, input int ack_delay);
    logic        memop, mis, timed, taken, done;
    int          nstall;
    logic [31:0] comp_rdata;
    wb_t         e;
    memop  = m2reg | wmem;
    mis    = memop && (addr[1:0] != 2'b00);
    timed  = memop && !mis && (ack_delay < 0 || ack_delay > TO);
    nstall = (!memop || mis) ? 0 : (timed ? TO : ack_delay);
    taken  = (jt == 2'd1 && zero) || (jt == 2'd2 && !zero) || (jt == 2'd3);
    if (m2reg) comp_rdata = mem_model.exists(addr) ? mem_model[addr] : 32'h0;
    else       comp_rdata = 32'h0000_5A5A;
    e.wreg  = wreg;
    e.m2reg = m2reg;
    e.wn    = wn;
    e.alu   = addr;
    e.mdata = ((memop && mis) || timed) ? ERR : comp_rdata;
    sb.push_back(e);
    err_exp = err_exp | (memop && mis) | timed;
    done = 1'b0;
    for (int c = 0; c <= TO + 8; c++) begin
      MEMwreg = wreg; MEMm2reg = m2reg; MEMwmem = wmem; MEMwn = wn;
      MEMaluResult = addr; MEMdi = wdata; MEMjumpType = jt; MEMjumpPc = 32'h40; MEMzero = zero;
      dm_ack   = (c == ack_delay);
      dm_rdata = (c == nstall && !timed) ? comp_rdata : $urandom;
      #1;
      vectors++;
      if (dm_req !== (memop && !mis))
        begin miscompares++; $display("FAIL dm_req c=%0d: got %b expected %b", c, dm_req, memop && !mis); end
      vectors++;
      if (stall !== (c < nstall))
        begin miscompares++; $display("FAIL stall c=%0d: got %b expected %b", c, stall, c < nstall); end
      vectors++;
      if (redirect !== (taken && c >= nstall))
        begin miscompares++; $display("FAIL redirect c=%0d: got %b expected %b", c, redirect, taken && c >= nstall); end
      if (taken) begin
        vectors++;
        if (redirect_pc !== 32'h40)
          begin miscompares++; $display("FAIL redirect_pc: got %h expected %h", redirect_pc, 32'h40); end
      end
      if (c == 0 && memop && !mis) begin
        vectors++;
        if (dm_we !== wmem || dm_addr !== addr || dm_wdata !== wdata)
          begin miscompares++; $display("FAIL dm_bus: got we=%b a=%h d=%h expected we=%b a=%h d=%h", dm_we, dm_addr, dm_wdata, wmem, addr, wdata); end
      end
      if (c >= 1) begin
        vectors++;
        if (WBwreg !== 1'b0)
          begin miscompares++; $display("FAIL bubble c=%0d: got WBwreg=%b expected 0", c, WBwreg); end
      end
      if (c == ack_delay && wmem && !mis) mem_model[addr] = wdata;
      @(negedge clk);
      if (c >= nstall) begin done = 1'b1; break; end
    end
    if (!done) begin miscompares++; $display("FAIL op_bound: got no completion expected one within %0d cycles", TO + 8); end
    e = sb.pop_front();
    vectors++;
    if (WBwreg !== e.wreg || WBm2reg !== e.m2reg || WBwn !== e.wn)
      begin miscompares++; $display("FAIL wb_ctrl: got wreg=%b m2reg=%b wn=%0d expected wreg=%b m2reg=%b wn=%0d", WBwreg, WBm2reg, WBwn, e.wreg, e.m2reg, e.wn); end
    vectors++;
    if (WBaluResult !== e.alu)
      begin miscompares++; $display("FAIL wb_alu: got %h expected %h", WBaluResult, e.alu); end
    vectors++;
    if (WBmemData !== e.mdata)
      begin miscompares++; $display("FAIL wb_mdata: got %h expected %h", WBmemData, e.mdata); end
    vectors++;
    if (dm_err !== err_exp)
      begin miscompares++; $display("FAIL dm_err: got %b expected %b", dm_err, err_exp); end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    drive_nop();
    repeat (2) @(negedge clk);
    vectors++;
    if ({WBwreg, WBm2reg, WBwn, WBaluResult, WBmemData, dm_err} !== '0)
      begin miscompares++; $display("FAIL reset_regs: got wreg=%b m2r=%b wn=%0d alu=%h md=%h err=%b expected all 0", WBwreg, WBm2reg, WBwn, WBaluResult, WBmemData, dm_err); end
    vectors++;
    if (dm_req !== 1'b0 || stall !== 1'b0)
      begin miscompares++; $display("FAIL reset_comb: got req=%b stall=%b expected 0 0", dm_req, stall); end
    clr = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_op(1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'h12345678, 2'd0, 1'b0, 0);
    do_op(1'b1, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0,       2'd0, 1'b0, 0);
    do_op(1'b1, 1'b1, 1'b0, 5'd4, 32'h14, 32'h0,       2'd0, 1'b0, 0);
  endtask

  task automatic test_wait_states();
    do_op(1'b0, 1'b0, 1'b1, 5'd0, 32'h18, 32'hA5A5_0F0F, 2'd0, 1'b0, 1);
    do_op(1'b1, 1'b1, 1'b0, 5'd7, 32'h18, 32'h0,         2'd0, 1'b0, 3);
    do_op(1'b1, 1'b1, 1'b0, 5'd8, 32'h10, 32'h0,         2'd0, 1'b0, TO);
  endtask

  task automatic test_timeout();
    do_op(1'b1, 1'b1, 1'b0, 5'd9,  32'h24, 32'h0,  2'd0, 1'b0, -1);
    do_op(1'b1, 1'b0, 1'b0, 5'd10, 32'h99, 32'h0,  2'd0, 1'b0, -1);
  endtask

  task automatic test_misaligned();
    do_op(1'b1, 1'b1, 1'b0, 5'd11, 32'h13, 32'h0,        2'd0, 1'b0, -1);
    do_op(1'b0, 1'b0, 1'b1, 5'd0,  32'h13, 32'hFFFF0000, 2'd0, 1'b0, -1);
    do_op(1'b1, 1'b1, 1'b0, 5'd12, 32'h10, 32'h0,        2'd0, 1'b0, 0);
  endtask

  task automatic test_redirect();
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd1, 1'b1, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd1, 1'b0, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd2, 1'b0, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd2, 1'b1, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd3, 1'b0, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd3, 1'b1, -1);
    do_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b1, -1);
    // Stall must suppress a redirect presented together with a waiting load.
    do_op(1'b1, 1'b1, 1'b0, 5'd13, 32'h10, 32'h0, 2'd3, 1'b0, 2);
  endtask

  task automatic test_clr_mid_wait();
    drive_nop();
    MEMwreg = 1'b1; MEMm2reg = 1'b1; MEMwn = 5'd14; MEMaluResult = 32'h30;
    repeat (3) @(negedge clk);
    vectors++;
    if (dm_req !== 1'b1 || stall !== 1'b1)
      begin miscompares++; $display("FAIL pre_clr: got req=%b stall=%b expected 1 1", dm_req, stall); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive_nop();
    dm_ack = 1'b1;
    dm_rdata = 32'h7777_7777;
    err_exp = 1'b0;
    #1;
    vectors++;
    if (dm_req !== 1'b0 || stall !== 1'b0)
      begin miscompares++; $display("FAIL post_clr_comb: got req=%b stall=%b expected 0 0", dm_req, stall); end
    vectors++;
    if ({WBwreg, WBm2reg, WBwn, WBaluResult, WBmemData, dm_err} !== '0)
      begin miscompares++; $display("FAIL post_clr_regs: got wreg=%b m2r=%b wn=%0d alu=%h md=%h err=%b expected all 0", WBwreg, WBm2reg, WBwn, WBaluResult, WBmemData, dm_err); end
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    vectors++;
    if (dm_req !== 1'b0 || stall !== 1'b0 || WBwreg !== 1'b0 || dm_err !== 1'b0)
      begin miscompares++; $display("FAIL late_ack: got req=%b stall=%b wreg=%b err=%b expected 0 0 0 0", dm_req, stall, WBwreg, dm_err); end
    @(negedge clk);
    do_op(1'b1, 1'b1, 1'b0, 5'd15, 32'h18, 32'h0, 2'd0, 1'b0, 2);
  endtask

  initial begin
    clr = 1'b1;
    drive_nop();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_misaligned();
    test_redirect();
    test_clr_mid_wait();
    drive_nop();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
